// File: rtl/alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_issuer
// Purpose  : RV32I OP/OP-IMM decode and issue front end for the combinational
//            ALU, with valid/ready handshakes on both sides.
//            Optional ALU_ISSUE_PERF_EN adds perf_ops/perf_stalls counters.
// Revision : 1.0 - initial release
// ============================================================================

package alu_op_issuer_pkg;
    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_SLTU = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_control_t;
endpackage

module alu_op_issuer
    import alu_op_issuer_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_instr,
    input  logic [N-1:0] in_rs1,
    input  logic [N-1:0] in_rs2,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output alu_control_t alu_control,
    input  logic [N-1:0] alu_result,
    input  logic         alu_overflow,
    input  logic         alu_zero,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [4:0]   out_rd,
    output logic         out_overflow,
    output logic         out_zero,
    output logic         out_illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]  perf_ops,
    output logic [31:0]  perf_stalls
`endif
);

    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_F7_BASE    = 7'b0000000;
    localparam logic [6:0] C_F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic         r_illegal;
    logic [4:0]   r_rd;

    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    logic         w_accept;
    logic         w_legal;
    alu_control_t w_ctrl;
    logic [N-1:0] w_b;
    logic         w_unused_rs1_field;

    assign w_opcode           = in_instr[6:0];
    assign w_funct3           = in_instr[14:12];
    assign w_funct7           = in_instr[31:25];
    assign w_unused_rs1_field = ^in_instr[19:15];

    assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_legal = 1'b0;
        w_ctrl  = ALU_AND;
        w_b     = '0;
        case (w_opcode)
            C_OPC_OP: begin
                w_b = in_rs2;
                if (w_funct7 == C_F7_BASE) begin
                    w_legal = 1'b1;
                    case (w_funct3)
                        3'b000:  w_ctrl = ALU_ADD;
                        3'b001:  w_ctrl = ALU_SLL;
                        3'b010:  w_ctrl = ALU_SLT;
                        3'b011:  w_ctrl = ALU_SLTU;
                        3'b100:  w_ctrl = ALU_XOR;
                        3'b101:  w_ctrl = ALU_SRL;
                        3'b110:  w_ctrl = ALU_OR;
                        default: w_ctrl = ALU_AND;
                    endcase
                end else if (w_funct7 == C_F7_ALT) begin
                    if (w_funct3 == 3'b000) begin
                        w_legal = 1'b1;
                        w_ctrl  = ALU_SUB;
                    end else if (w_funct3 == 3'b101) begin
                        w_legal = 1'b1;
                        w_ctrl  = ALU_SRA;
                    end
                end
            end
            C_OPC_OP_IMM: begin
                w_b     = {{(N-12){in_instr[31]}}, in_instr[31:20]};
                w_legal = 1'b1;
                case (w_funct3)
                    3'b000: w_ctrl = ALU_ADD;
                    3'b010: w_ctrl = ALU_SLT;
                    3'b011: w_ctrl = ALU_SLTU;
                    3'b100: w_ctrl = ALU_XOR;
                    3'b110: w_ctrl = ALU_OR;
                    3'b111: w_ctrl = ALU_AND;
                    3'b001: begin
                        // Shift-immediates carry a 5-bit shamt, not a signed immediate
                        w_b     = {{(N-5){1'b0}}, in_instr[24:20]};
                        w_legal = (w_funct7 == C_F7_BASE);
                        w_ctrl  = ALU_SLL;
                    end
                    default: begin
                        w_b     = {{(N-5){1'b0}}, in_instr[24:20]};
                        w_legal = (w_funct7 == C_F7_BASE) || (w_funct7 == C_F7_ALT);
                        w_ctrl  = (w_funct7 == C_F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= ALU_AND;
            r_rd        <= '0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            alu_a       <= w_legal ? in_rs1 : '0;
            alu_b       <= w_legal ? w_b : '0;
            alu_control <= w_legal ? w_ctrl : ALU_AND;
            r_rd        <= in_instr[11:7];
            r_illegal   <= ~w_legal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_rd       <= '0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_illegal  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Illegal ops report a clean zero result regardless of the ALU
                    out_result   <= r_illegal ? '0 : alu_result;
                    out_overflow <= r_illegal ? 1'b0 : alu_overflow;
                    out_zero     <= r_illegal ? 1'b1 : alu_zero;
                    out_illegal  <= r_illegal;
                    out_rd       <= r_rd;
                    out_valid    <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= in_valid ? S_EXEC : S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ops    <= '0;
            perf_stalls <= '0;
        end else if (out_valid) begin
            if (out_ready) begin
                perf_ops <= perf_ops + 32'd1;
            end else begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
